// File: rtl/shift_arbiter_if.sv
// Requester handshake plus shift-register control bundle for shift_arbiter_ctrl.
// The master side is the requesters and register; the slave side is the arbiter.
interface shift_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic [1:0]       req;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic [CNT_W-1:0] count0;
   logic [CNT_W-1:0] count1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             busy;
   logic             load_n;
   logic             shift;
   logic [WIDTH-1:0] load_val;

   modport master (
      output req, data0, data1, count0, count1,
      input  gnt, done, busy, load_n, shift, load_val
   );

   modport slave (
      input  req, data0, data1, count0, count1,
      output gnt, done, busy, load_n, shift, load_val
   );
endinterface

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter and sequencer for one shared shift-right register:
// grants a requester, loads its value, issues its shift count, pulses done.
module shift_arbiter_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   shift_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic             winner, winner_nx;
   logic             last_served, last_served_nx;
   logic [WIDTH-1:0] data_w, data_nx;
   logic [CNT_W-1:0] count_w, count_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   logic             grant_win;
   logic [CNT_W-1:0] req_count;
   logic [CNT_W-1:0] req_count_clamped;
   logic [1:0]       winner_oh;

   // On a tie the requester that was not served last wins.
   always_comb begin
      case (bus.req)
         2'b10:   grant_win = 1'b1;
         2'b11:   grant_win = ~last_served;
         default: grant_win = 1'b0;
      endcase
      req_count = grant_win ? bus.count1 : bus.count0;
      if (int'(req_count) > WIDTH) req_count_clamped = CNT_W'(WIDTH);
      else                         req_count_clamped = req_count;
   end

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nx       = state;
      winner_nx      = winner;
      last_served_nx = last_served;
      data_nx        = data_w;
      count_nx       = count_w;
      cnt_nx         = cnt;

      case (state)
         IDLE: begin
            if (bus.req != 2'b00) begin
               winner_nx      = grant_win;
               last_served_nx = grant_win;
               data_nx        = grant_win ? bus.data1 : bus.data0;
               count_nx       = req_count_clamped;
               state_nx       = LOAD;
            end
         end
         LOAD: begin
            cnt_nx   = count_w;
            state_nx = (count_w != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Moore outputs: decoded only from registered state and latched transaction.
   always_comb begin
      winner_oh    = winner ? 2'b10 : 2'b01;
      bus.gnt      = (state != IDLE) ? winner_oh : 2'b00;
      bus.done     = (state == DONE) ? winner_oh : 2'b00;
      bus.busy     = (state != IDLE);
      bus.load_n   = (state != LOAD);
      bus.shift    = (state == SHIFT);
      bus.load_val = data_w;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         winner      <= 1'b0;
         last_served <= 1'b1;
         data_w      <= '0;
         count_w     <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_nx;
         winner      <= winner_nx;
         last_served <= last_served_nx;
         data_w      <= data_nx;
         count_w     <= count_nx;
         cnt         <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Scoreboard bench for shift_arbiter_ctrl: driver predicts each transaction's
// outcome from the arbitration rules; a monitor checks it when done pulses.
module tb_shift_arbiter_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   typedef struct {
      logic [1:0]       who_oh;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] result;
      int               n;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   bit   model_last = 1'b1;
   exp_t sb[$];
   logic [WIDTH-1:0] reg_model = '0;
   int   cyc = 0;
   int   shifts = 0;

   shift_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_arbiter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: run did not finish (got no finish, required finish)");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // External shift register driven by the DUT's control outputs.
   always @(posedge clock) begin
      if (bus.load_n === 1'b0)    reg_model <= bus.load_val;
      else if (bus.shift === 1'b1) reg_model <= reg_model >> 1;
   end

   // Monitor: samples on the falling edge, pops the scoreboard on each done pulse.
   always @(negedge clock) begin
      if (mon_en) begin
         if (bus.load_n === 1'b0) begin
            if (sb.size() == 0) check("load_without_request", 32'd1, 32'd0);
            else begin
               check("load_gnt", bus.gnt, sb[0].who_oh);
               check("load_val", bus.load_val, sb[0].data);
            end
            cyc = 0;
            shifts = 0;
         end else begin
            cyc++;
            if (bus.shift === 1'b1) shifts++;
         end
         check("gnt_onehot", $countones(bus.gnt) <= 1, 32'd1);
         check("busy_vs_gnt", bus.busy, |bus.gnt);
         if (bus.done !== 2'b00) begin
            if (sb.size() == 0) check("spurious_done", bus.done, 2'b00);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("done_who", bus.done, e.who_oh);
               check("done_gnt", bus.gnt, e.who_oh);
               check("reg_result", reg_model, e.result);
               check("shift_cycles", shifts, e.n);
               check("done_latency", cyc, e.n + 1);
            end
         end
      end
   end

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         bus.req = 2'b00;
         @(posedge clock);
      end
   endtask

   // One transaction: set inputs before the grant edge, predict the outcome,
   // optionally scramble inputs during it, optionally reset at cycle abort_at.
   task automatic do_txn(input logic [1:0] r, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                         input bit scramble, input int abort_at);
      exp_t e;
      bit   w;
      int   c;
      @(negedge clock);
      bus.req = r; bus.data0 = d0; bus.data1 = d1; bus.count0 = c0; bus.count1 = c1;
      w = (r == 2'b10) || (r == 2'b11 && model_last == 1'b0);
      model_last = w;
      c = w ? int'(c1) : int'(c0);
      e.n = (c > WIDTH) ? WIDTH : c;
      e.data = w ? d1 : d0;
      e.result = e.data >> e.n;
      e.who_oh = w ? 2'b10 : 2'b01;
      @(posedge clock);
      sb.push_back(e);
      for (int i = 0; i < 2 + e.n; i++) begin
         @(negedge clock);
         if (i == abort_at) begin
            reset_n = 1'b0;
            bus.req = 2'b00;
            @(posedge clock);
            #1;
            sb.delete();
            model_last = 1'b1;
            @(negedge clock);
            check("abort_busy", bus.busy, 1'b0);
            check("abort_gnt", bus.gnt, 2'b00);
            check("abort_shift", bus.shift, 1'b0);
            check("abort_done", bus.done, 2'b00);
            check("abort_load_n", bus.load_n, 1'b1);
            reset_n = 1'b1;
            return;
         end
         if (scramble) begin
            bus.data0 = WIDTH'($urandom); bus.data1 = WIDTH'($urandom);
            bus.count0 = CNT_W'($urandom); bus.count1 = CNT_W'($urandom);
            bus.req = 2'($urandom);
         end
         @(posedge clock);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.req = 2'b00; bus.data0 = '0; bus.data1 = '0; bus.count0 = '0; bus.count1 = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_gnt", bus.gnt, 2'b00);
      check("rst_done", bus.done, 2'b00);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_load_n", bus.load_n, 1'b1);
      check("rst_shift", bus.shift, 1'b0);
      check("rst_load_val", bus.load_val, '0);
      reset_n = 1'b1;
      mon_en = 1'b1;

      do_txn(2'b01, 8'hA5, 8'h00, 4'd3, 4'd0, 1'b0, -1);
      idle(2);
      do_txn(2'b10, 8'h00, 8'h3C, 4'd0, 4'd0, 1'b0, -1);
      idle(2);
      for (int i = 0; i < 4; i++) do_txn(2'b11, 8'h81 + 8'(i), 8'h42 + 8'(i), 4'd1, 4'd1, 1'b0, -1);
      idle(1);
      do_txn(2'b01, 8'hFF, 8'h00, 4'hF, 4'd0, 1'b0, -1);
      idle(1);
      do_txn(2'b01, 8'hC3, 8'h00, 4'd5, 4'd0, 1'b0, 2);
      do_txn(2'b11, 8'h96, 8'h69, 4'd2, 4'd6, 1'b0, -1);
      do_txn(2'b01, 8'hB7, 8'h11, 4'd4, 4'd2, 1'b1, -1);

      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
         do_txn(2'($urandom_range(1, 3)), WIDTH'($urandom), WIDTH'($urandom),
                CNT_W'($urandom), CNT_W'($urandom), 1'($urandom), -1);
      end

      idle(5);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
